// File: rtl/core_pkg.sv
// Shared core types: hazard FSM encoding,
// NOP encoding and register-index width.
package core_pkg;

  localparam int REG_W = 5;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Hazard performance counters and the
// sticky data-memory wait watchdog.
module hazard_perf_cnt #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_inc,
  input  logic             flush_inc,
  input  logic             wait_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  logic [15:0] wd_q;
  logic [16:0] wd_nx;

  assign wd_nx = {1'b0, wd_q} + 17'd1;

  // Wrapping counters; watchdog runs only across a freeze streak
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      wd_q        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (stall_inc)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc)
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (wait_inc) begin
        if (wd_q != 16'hFFFF)
          wd_q <= wd_nx[15:0];
        if (wd_nx >= 17'(MEM_TIMEOUT))
          mem_timeout <= 1'b1;
      end else begin
        wd_q <= '0;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall / bubble / flush control for the
// 5-stage pipe: load-use, redirect, dmem wait.
module hazard_unit
  import core_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic             ex_is_load,
  input  logic [4:0]       rd_ex,
  input  logic             branch_taken_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int LU_W = 2;

  hz_state_t state_q, state_d;
  logic [LU_W-1:0] lu_q, lu_d;
  logic lu_hazard;
  logic mem_stall;
  logic rs1_hit, rs2_hit;

  assign rs1_hit = use_rs1_id && (rs1_id == rd_ex);
  assign rs2_hit = use_rs2_id && (rs2_id == rd_ex);
  assign lu_hazard = ex_is_load && (rd_ex != '0)
                   && (rs1_hit || rs2_hit);
  assign mem_stall = dmem_req && !dmem_ready;

  // Mealy controls: freeze > redirect > load-use
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    state_d      = state_q;
    lu_d         = lu_q;
    if (!rst_n) begin
      state_d = RUN;
      lu_d    = '0;
    end else if (mem_stall) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      state_d      = MEM_WAIT;
    end else if (branch_taken_ex) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
      lu_d        = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (lu_hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              state_d = LU_STALL;
              lu_d    = LU_W'(LOAD_USE_CYCLES - 1);
            end
          end
        end
        LU_STALL: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          lu_d        = lu_q - LU_W'(1);
          if (lu_q <= LU_W'(1))
            state_d = RUN;
        end
        MEM_WAIT: begin
          if (lu_q != '0) begin
            state_d = LU_STALL;
          end else begin
            state_d = RUN;
            if (lu_hazard) begin
              pc_en       = 1'b0;
              ifid_en     = 1'b0;
              idex_bubble = 1'b1;
              if (LOAD_USE_CYCLES > 1) begin
                state_d = LU_STALL;
                lu_d    = LU_W'(LOAD_USE_CYCLES - 1);
              end
            end
          end
        end
        default: begin
          state_d = RUN;
          lu_d    = '0;
        end
      endcase
    end
  end

  // FSM state and remaining load-use stall count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      lu_q    <= '0;
    end else begin
      state_q <= state_d;
      lu_q    <= lu_d;
    end
  end

  hazard_perf_cnt #(
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_inc   (!pc_en),
    .flush_inc   (ifid_flush),
    .wait_inc    (memwb_bubble),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .mem_timeout (mem_timeout)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: two
// instances (1-cycle and 3-cycle load-use).
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1_id = '0;
  logic [4:0] rs2_id = '0;
  logic use_rs1_id = 1'b0;
  logic use_rs2_id = 1'b0;
  logic ex_is_load = 1'b0;
  logic [4:0] rd_ex = '0;
  logic branch_taken_ex = 1'b0;
  logic dmem_req = 1'b0;
  logic dmem_ready = 1'b0;

  logic pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a;
  logic idex_bubble_a, exmem_en_a, memwb_bubble_a, mto_a;
  logic [31:0] stall_a, flush_a;
  logic pc_en_b, ifid_en_b, ifid_flush_b, idex_en_b;
  logic idex_bubble_b, exmem_en_b, memwb_bubble_b, mto_b;
  logic [31:0] stall_b, flush_b;
  logic [6:0] ctrl_a, ctrl_b;

  localparam logic [6:0] DEF = 7'b1101010;
  localparam logic [6:0] LU  = 7'b0001110;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [6:0] FLS = 7'b1111110;

  typedef struct {
    string      tag;
    bit         sel;
    logic [6:0] ctrl;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_unit #(
    .LOAD_USE_CYCLES (1),
    .MEM_TIMEOUT     (255),
    .CNT_W           (32)
  ) dut_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .use_rs1_id      (use_rs1_id),
    .use_rs2_id      (use_rs2_id),
    .ex_is_load      (ex_is_load),
    .rd_ex           (rd_ex),
    .branch_taken_ex (branch_taken_ex),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en_a),
    .ifid_en         (ifid_en_a),
    .ifid_flush      (ifid_flush_a),
    .idex_en         (idex_en_a),
    .idex_bubble     (idex_bubble_a),
    .exmem_en        (exmem_en_a),
    .memwb_bubble    (memwb_bubble_a),
    .mem_timeout     (mto_a),
    .stall_cnt       (stall_a),
    .flush_cnt       (flush_a)
  );

  hazard_unit #(
    .LOAD_USE_CYCLES (3),
    .MEM_TIMEOUT     (8),
    .CNT_W           (32)
  ) dut_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .use_rs1_id      (use_rs1_id),
    .use_rs2_id      (use_rs2_id),
    .ex_is_load      (ex_is_load),
    .rd_ex           (rd_ex),
    .branch_taken_ex (branch_taken_ex),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en_b),
    .ifid_en         (ifid_en_b),
    .ifid_flush      (ifid_flush_b),
    .idex_en         (idex_en_b),
    .idex_bubble     (idex_bubble_b),
    .exmem_en        (exmem_en_b),
    .memwb_bubble    (memwb_bubble_b),
    .mem_timeout     (mto_b),
    .stall_cnt       (stall_b),
    .flush_cnt       (flush_b)
  );

  assign ctrl_a = {pc_en_a, ifid_en_a, ifid_flush_a,
                   idex_en_a, idex_bubble_a,
                   exmem_en_a, memwb_bubble_a};
  assign ctrl_b = {pc_en_b, ifid_en_b, ifid_flush_b,
                   idex_en_b, idex_bubble_b,
                   exmem_en_b, memwb_bubble_b};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the expected controls
  task automatic cyc(input string tag, input bit sel,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input bit u1, input bit u2, input bit ld,
                     input logic [4:0] rd, input bit br,
                     input bit req, input bit rdy,
                     input logic [6:0] exp);
    exp_t e;
    @(negedge clk);
    rs1_id = r1;
    rs2_id = r2;
    use_rs1_id = u1;
    use_rs2_id = u2;
    ex_is_load = ld;
    rd_ex = rd;
    branch_taken_ex = br;
    dmem_req = req;
    dmem_ready = rdy;
    e.tag = tag;
    e.sel = sel;
    e.ctrl = exp;
    sb.push_back(e);
  endtask

  task automatic idle(input string tag, input bit sel);
    cyc(tag, sel, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rs1_id = '0;
    rs2_id = '0;
    use_rs1_id = 1'b0;
    use_rs2_id = 1'b0;
    ex_is_load = 1'b0;
    rd_ex = '0;
    branch_taken_ex = 1'b0;
    dmem_req = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pop and compare Mealy controls mid-cycle
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, 32'(e.sel ? ctrl_b : ctrl_a), 32'(e.ctrl));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=done");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    settle();
    check("rst_stall_a", stall_a, 0);
    check("rst_flush_a", flush_a, 0);
    check("rst_mto_b", 32'(mto_b), 0);
    idle("rst_def_a", 0);
    idle("rst_def_b", 1);

    cyc("lu1_rs1", 0, 5, 0, 1, 0, 1, 5, 0, 0, 0, LU);
    idle("lu1_after", 0);
    settle();
    check("lu1_stall_cnt", stall_a, 1);

    cyc("lu_rd0", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, DEF);
    cyc("lu_nouse1", 0, 5, 0, 0, 0, 1, 5, 0, 0, 0, DEF);
    cyc("lu_nouse2", 0, 0, 5, 0, 0, 1, 5, 0, 0, 0, DEF);
    settle();
    check("nolu_stall_cnt", stall_a, 1);

    do_reset();
    cyc("lu3_c1", 1, 0, 7, 0, 1, 1, 7, 0, 0, 0, LU);
    idle("lu3_c2", 1);
    sb[$].ctrl = LU;
    idle("lu3_c3", 1);
    sb[$].ctrl = LU;
    idle("lu3_run", 1);
    settle();
    check("lu3_stall_cnt", stall_b, 3);

    do_reset();
    cyc("lum_c1", 1, 0, 7, 0, 1, 1, 7, 0, 0, 0, LU);
    for (int i = 0; i < 4; i++)
      cyc("lum_frz", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
    cyc("lum_rdy", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, DEF);
    idle("lum_lu2", 1);
    sb[$].ctrl = LU;
    idle("lum_lu3", 1);
    sb[$].ctrl = LU;
    idle("lum_run", 1);
    settle();
    check("lum_stall_cnt", stall_b, 7);
    check("lum_mto", 32'(mto_b), 0);

    do_reset();
    cyc("br_lu", 0, 5, 0, 1, 0, 1, 5, 1, 0, 0, FLS);
    idle("br_after", 0);
    settle();
    check("br_flush_cnt", flush_a, 1);
    check("br_stall_cnt", stall_a, 0);

    do_reset();
    cyc("brk_c1", 1, 9, 0, 1, 0, 1, 9, 0, 0, 0, LU);
    cyc("brk_br", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, FLS);
    idle("brk_run", 1);
    cyc("brk_memwin", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ);
    idle("brk_end", 1);
    settle();
    check("brk_stall_cnt", stall_b, 2);
    check("brk_flush_cnt", flush_b, 1);

    do_reset();
    for (int i = 0; i < 7; i++)
      cyc("wd_frz", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
    settle();
    check("wd_7", 32'(mto_b), 0);
    cyc("wd_frz8", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
    settle();
    check("wd_8", 32'(mto_b), 1);
    cyc("wd_rdy", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, DEF);
    idle("wd_idle", 1);
    settle();
    check("wd_sticky", 32'(mto_b), 1);

    cyc("rstmid_frz", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
    settle();
    rst_n = 1'b0;
    #2;
    check("rstmid_ctrl", 32'(ctrl_b), 32'(DEF));
    check("rstmid_stall", stall_b, 0);
    check("rstmid_flush", flush_b, 0);
    check("rstmid_mto", 32'(mto_b), 0);
    @(negedge clk);
    dmem_req = 1'b0;
    rst_n = 1'b1;

    repeat (3) @(negedge clk);
    if (sb.size() != 0)
      check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage integer core. It produces the stall, bubble and flush controls that the forwarding unit cannot resolve.
- Handled cases: load-use hazards (stall ID, bubble EX), taken-branch redirects (flush IF/ID, bubble EX) and data-memory wait states (freeze the whole pipe).
- Sits beside forward_unit. It consumes the same rs/rd/write-enable view of ID and EX, plus memory handshake status.
- Keeps a small state machine for multi-cycle stalls, a memory-wait watchdog, and performance counters.

Parameters:
- LOAD_USE_CYCLES, 1, stall cycles inserted per load-use hazard (1..4; >1 for registered-output data RAM).
- MEM_TIMEOUT, 255, consecutive MEM_WAIT cycles before mem_timeout is set (1..65535).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- rs1_id  in  5  ID-stage source register 1
- rs2_id  in  5  ID-stage source register 2
- use_rs1_id  in  1  ID instruction actually reads rs1
- use_rs2_id  in  1  ID instruction actually reads rs2
- ex_is_load  in  1  EX-stage instruction is a load
- rd_ex  in  5  EX-stage destination register
- branch_taken_ex  in  1  EX resolved a taken branch or jump (redirect this cycle)
- dmem_req  in  1  MEM-stage instruction is accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_en  out  1  ID/EX register enable
- idex_bubble  out  1  load NOP into ID/EX
- exmem_en  out  1  EX/MEM register enable
- memwb_bubble  out  1  load NOP into MEM/WB
- mem_timeout  out  1  sticky watchdog flag
- stall_cnt  out  CNT_W  total cycles with pc_en=0
- flush_cnt  out  CNT_W  total taken-branch flushes

Behaviour:
- States: RUN, LU_STALL, MEM_WAIT. Reset state is RUN.
- Outputs are combinational from state and current inputs (Mealy).
- Default output values: all enables 1, all flush/bubble 0.
- lu_hazard = ex_is_load && rd_ex != 0 && ((use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex)).
- mem_stall = dmem_req && !dmem_ready.
- Priority in every state: mem_stall > branch_taken_ex > load-use.
- mem_stall, any state:
  - pc_en, ifid_en, idex_en and exmem_en = 0; memwb_bubble = 1; all other controls 0.
  - Next state MEM_WAIT. The prior state's remaining LU count is held and not decremented.
- MEM_WAIT:
  - Stays while mem_stall holds.
  - The cycle dmem_ready = 1 is a normal cycle: enables 1, and the other rules are evaluated.
  - Next state is LU_STALL if the held LU count is > 0, else RUN.
- branch_taken_ex with no mem_stall:
  - ifid_flush = 1, idex_bubble = 1, flush_cnt += 1, next state RUN.
  - Any LU count is cleared (the hazarding ID instruction is killed).
- RUN with lu_hazard:
  - pc_en = 0, ifid_en = 0, idex_bubble = 1.
  - If LOAD_USE_CYCLES > 1, go to LU_STALL with remaining = LOAD_USE_CYCLES-1; otherwise stay in RUN.
- LU_STALL:
  - Same outputs as the load-use stall; lu_hazard is ignored.
  - Decrement remaining; return to RUN when remaining reaches 0.
- stall_cnt increments every cycle pc_en = 0. flush_cnt increments per flush. Both wrap modulo 2^CNT_W.
- Watchdog: a 16-bit counter increments each MEM_WAIT cycle and clears on leaving MEM_WAIT. Reaching MEM_TIMEOUT sets mem_timeout, which is cleared only by reset.
- Reset (async, any time, including mid-stall) returns: state RUN, LU count 0, watchdog 0, counters 0, mem_timeout 0. Outputs immediately revert to defaults.
- rd_ex = 0 never causes a load-use stall.

Decomposition:
- Shared package core_pkg holds the hazard state encoding enum (RUN=0, LU_STALL=1, MEM_WAIT=2), the NOP encoding constant, and the register-index width constant (5).
- One natural sub-module: hazard_perf_cnt, containing the two wrapping counters and the watchdog.

Test Plan:
- Load x5 in EX, ID reads rs1=x5 with use_rs1_id=1, LOAD_USE_CYCLES=1 -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1, then defaults; stall_cnt=1.
- Same hazard with rd_ex=0, or use_rs1_id=0 -> no stall, all defaults.
- LOAD_USE_CYCLES=3, load-use on rs2 -> exactly 3 stall cycles, then RUN; stall_cnt=3.
- dmem_req=1 with dmem_ready low for 4 cycles during a 3-cycle LU stall (from its 2nd cycle) -> 4 freeze cycles with memwb_bubble=1, then the remaining 2 LU cycles; stall_cnt=7.
- branch_taken_ex and lu_hazard in the same cycle -> ifid_flush=1, idex_bubble=1, pc_en=1, flush_cnt=1, no stall.
- MEM_TIMEOUT=8, dmem_ready held low 8 cycles -> mem_timeout=1 on the 8th wait cycle and stays set after ready. Asserting rst_n=0 mid-wait -> all outputs at defaults, counters 0, mem_timeout 0.
